// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: up/down BCD counter with a multiplexed display scanner.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   inc, dec, clr     count up, count down (both at once = hold), synchronous clear
//   a, b, c, d        BCD nibble of the digit being scanned (a = MSB)
//   an                active-low one-hot digit enable
//   value             full BCD count, digit 0 in bits [3:0]
//   wrap              one-cycle pulse after the count wraps in either direction
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a scanned digit above digit 0 that is zero and has only zero
//   digits above it drives {a,b,c,d} = 4'b1111, which the downstream decoder
//   shows as a dark digit. When undefined, {a,b,c,d} is always the digit value.
module bcd_scan_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  clr,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] count_q;
  logic [DIGITS-1:0][3:0] count_d;
  logic [PRE_W-1:0]       pre_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   wrap_q;
  logic                   wrap_d;
  logic                   ripple;
  logic [3:0]             nibble;

  // Next count: ripple carry/borrow through the digits, wrap when it leaves the top.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ripple  = 1'b1;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (ripple) begin
          if (count_q[i] >= 4'd9) begin
            count_d[i] = 4'd0;
          end else begin
            count_d[i] = count_q[i] + 4'd1;
            ripple     = 1'b0;
          end
        end
      end
      wrap_d = ripple;
    end else if (dec && !inc) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (ripple) begin
          if (count_q[i] == 4'd0) begin
            count_d[i] = 4'd9;
          end else begin
            count_d[i] = count_q[i] - 4'd1;
            ripple     = 1'b0;
          end
        end
      end
      wrap_d = ripple;
    end
  end

  // Count, wrap pulse, prescaler and scan index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      if (pre_q == PRE_LAST) begin
        pre_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] upper_zero;
  logic              zero_run;

  // upper_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run      = zero_run && (count_q[i] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  // Digit 0 always shows, so a zero count still displays "0".
  always_comb begin
    nibble = count_q[idx_q];
    if ((idx_q != '0) && upper_zero[idx_q]) begin
      nibble = 4'hF;
    end
  end
`else
  always_comb begin
    nibble = count_q[idx_q];
  end
`endif

  // Display path is combinational from the registers so count changes show at once.
  assign {a, b, c, d} = nibble;
  assign an           = ~(DIGITS'(1) << idx_q);
  assign value        = count_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed stimulus with a cycle-stamped scoreboard for
// bcd_scan_counter (DIGITS=4, SCAN_DIV=4). Honours LEADING_ZERO_BLANK_EN.
module tb_bcd_scan_counter;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;

  localparam int K_VALUE = 0;
  localparam int K_WRAP  = 1;
  localparam int K_AN    = 2;
  localparam int K_ABCD  = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc   = 1'b0;
  logic        dec   = 1'b0;
  logic        clr   = 1'b0;
  logic        a, b, c, d;
  logic [3:0]  an;
  logic [15:0] value;
  logic        wrap;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  int          spre   = 0;
  int          sidx   = 0;
  exp_t        mon_e;
  logic [15:0] mon_act;
  logic [3:0]  lzb_tbl [4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bcd_scan_counter #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .dec   (dec),
    .clr   (clr),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .an    (an),
    .value (value),
    .wrap  (wrap)
  );

  // Expected display nibble for a count and scan slot.
  function automatic logic [3:0] exp_nib(input logic [15:0] v, input int idx);
    logic [3:0] n;
    n = v[idx*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (v >> (idx * 4)) == 16'h0) n = 4'hF;
`endif
    return n;
  endfunction

  task automatic push(input int kind, input logic [15:0] v, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk_state(input logic [15:0] v, input logic w, input string tag);
    logic [3:0] ae;
    ae = ~(4'b0001 << sidx);
    push(K_VALUE, v, {tag, ".value"});
    push(K_WRAP, {15'h0, w}, {tag, ".wrap"});
    push(K_AN, {12'h0, ae}, {tag, ".an"});
    push(K_ABCD, {12'h0, exp_nib(v, sidx)}, {tag, ".abcd"});
  endtask

  // One clock; inputs change 1 time unit after the edge. Tracks the scan position.
  task automatic step();
    logic r;
    r = rst_n;
    @(posedge clk);
    #1;
    if (!r) begin
      spre = 0;
      sidx = 0;
    end else if (spre == int'(SCAN_DIV) - 1) begin
      spre = 0;
      sidx = (sidx + 1) % int'(DIGITS);
    end else begin
      spre++;
    end
  endtask

  // Monitor: every expectation stamped with this cycle is compared at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_VALUE: mon_act = value;
        K_WRAP:  mon_act = {15'h0, wrap};
        K_AN:    mon_act = {12'h0, an};
        default: mon_act = {12'h0, a, b, c, d};
      endcase
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: entry for cycle %0d not sampled until cycle %0d", mon_e.name, mon_e.cyc, cyc);
      end else if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", mon_e.name, mon_act, mon_e.exp, cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    lzb_tbl[0] = 4'b0000; lzb_tbl[1] = 4'b0111; lzb_tbl[2] = 4'b1111; lzb_tbl[3] = 4'b1111;
`else
    lzb_tbl[0] = 4'b0000; lzb_tbl[1] = 4'b0111; lzb_tbl[2] = 4'b0000; lzb_tbl[3] = 4'b0000;
`endif

    // Reset state, then idle scan sequence.
    step();
    step();
    chk_state(16'h0000, 1'b0, "reset");
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk_state(16'h0000, 1'b0, "idle");
      step();
    end

    // 1234 increments, no wrap on the way.
    inc = 1'b1;
    repeat (1234) begin
      step();
      push(K_WRAP, 16'h0, "count.wrap");
    end
    inc = 1'b0;
    chk_state(16'h1234, 1'b0, "count1234");
    for (int k = 0; k < 16; k++) begin
      chk_state(16'h1234, 1'b0, "scan1234");
      step();
    end
    while (sidx != 2) step();
    push(K_ABCD, 16'h0002, "slot2.abcd");
    push(K_AN, 16'h000B, "slot2.an");

    // Wrap pulses in both directions.
    clr = 1'b1; step(); clr = 1'b0;
    chk_state(16'h0000, 1'b0, "clr");
    dec = 1'b1; step(); dec = 1'b0;
    chk_state(16'h9999, 1'b1, "dec_wrap");
    step();
    chk_state(16'h9999, 1'b0, "dec_wrap_end");
    inc = 1'b1; step(); inc = 1'b0;
    chk_state(16'h0000, 1'b1, "inc_wrap");
    step();
    chk_state(16'h0000, 1'b0, "inc_wrap_end");
    dec = 1'b1; step(); dec = 1'b0;
    chk_state(16'h9999, 1'b1, "dec_wrap2");
    step();
    chk_state(16'h9999, 1'b0, "dec_wrap2_end");

    // Clear beats a decrement at zero, so no wrap.
    clr = 1'b1; step();
    dec = 1'b1; step(); clr = 1'b0; dec = 1'b0;
    chk_state(16'h0000, 1'b0, "clr_dec_prio");

    // inc and dec together hold; clr beats inc.
    inc = 1'b1; repeat (42) step(); inc = 1'b0;
    chk_state(16'h0042, 1'b0, "load42");
    inc = 1'b1; dec = 1'b1;
    repeat (10) begin
      step();
      chk_state(16'h0042, 1'b0, "incdec_hold");
    end
    dec = 1'b0; clr = 1'b1; step(); clr = 1'b0; inc = 1'b0;
    chk_state(16'h0000, 1'b0, "clr_inc");

    // Ripple borrow across two digits.
    inc = 1'b1; repeat (100) step(); inc = 1'b0;
    chk_state(16'h0100, 1'b0, "load100");
    dec = 1'b1; step(); dec = 1'b0;
    chk_state(16'h0099, 1'b0, "borrow");

    // 0x0070 across every scan slot.
    clr = 1'b1; step(); clr = 1'b0;
    inc = 1'b1; repeat (70) step(); inc = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_state(16'h0070, 1'b0, "scan70");
      step();
    end
    for (int s = 0; s < 4; s++) begin
      while (sidx != s) step();
      push(K_ABCD, {12'h0, lzb_tbl[s]}, "lzb70.abcd");
    end

    // Reset during a wrap pulse.
    clr = 1'b1; step(); clr = 1'b0;
    dec = 1'b1; step(); dec = 1'b0;
    rst_n = 1'b0;
    spre = 0;
    sidx = 0;
    chk_state(16'h0000, 1'b0, "rst_mid_wrap");
    step();
    rst_n = 1'b1;

    // Reset in slot 2, cycle 2; increment honoured on release.
    inc = 1'b1; repeat (5) step(); inc = 1'b0;
    chk_state(16'h0005, 1'b0, "load5");
    while (!(sidx == 2 && spre == 2)) step();
    rst_n = 1'b0;
    spre = 0;
    sidx = 0;
    chk_state(16'h0000, 1'b0, "rst_mid_scan");
    step();
    step();
    rst_n = 1'b1;
    inc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(K_AN, (k < 4) ? 16'h000E : 16'h000D, "post_rst.an");
      push(K_VALUE, (k == 0) ? 16'h0000 : 16'h0001, "post_rst.value");
      step();
      inc = 1'b0;
    end

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
